// File: rtl/sram_rd_pkg.sv
// Shared definitions for the SRAM read streamer: FSM state encoding and default sizes.
package sram_rd_pkg;

    localparam int DW_DEF = 64;
    localparam int AW_DEF = 14;
    localparam int FD_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/sram_rd_streamer_fifo.sv
// Synchronous skid FIFO; absorbs read data that is already in flight when downstream stalls.
module sync_fifo #(
    parameter int DW = 64,
    parameter int FD = 4,
    parameter int PW = $clog2(FD),
    parameter int CW = $clog2(FD) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [FD];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(FD));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// Burst read sequencer: issues credit-limited SRAM reads and streams the words out on valid/ready.
module sram_rd_streamer
    import sram_rd_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int MW = DW / 8,
    parameter int AW = AW_DEF,
    parameter int FD = FD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [MW-1:0] sram_wem,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int CW = $clog2(FD) + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   issue_left_q, issue_left_d;
    logic [AW:0]   recv_left_q, recv_left_d;
    logic          rd_pend_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          credit_ok;

    // Words in the FIFO plus the read still in flight must leave room for one more.
    assign credit_sum = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
    assign credit_ok  = (credit_sum < (CW+1)'(FD));

    assign fifo_push = rd_pend_q & ~fifo_full;
    assign fifo_pop  = m_valid & m_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        recv_left_d  = recv_left_q;
        sram_cs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    issue_left_d = len;
                    recv_left_d  = len;
                    state_d      = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue_left_q != '0 && credit_ok) begin
                    sram_cs      = 1'b1;
                    addr_d       = addr_q + AW'(1);
                    issue_left_d = issue_left_q - (AW+1)'(1);
                    if (issue_left_q == (AW+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_pop && recv_left_q == (AW+1)'(1)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fifo_pop) recv_left_d = recv_left_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            rd_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            recv_left_q  <= recv_left_d;
            rd_pend_q    <= sram_cs;
        end
    end

    sync_fifo #(
        .DW (DW),
        .FD (FD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sram_dout),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign sram_we   = 1'b0;
    assign sram_wem  = '0;
    assign sram_addr = addr_q;
    assign m_valid   = ~fifo_empty;
    assign m_last    = m_valid & (recv_left_q == (AW+1)'(1));

endmodule
